// File: rtl/change_pkg.sv
// Shared definitions for the change dispenser: cash width, FSM states,
// denomination codes and their unit values, and the default PAY timeout.
package change_pkg;

  localparam int unsigned CASH_W          = 7;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PAY,
    DONE,
    FAULT
  } state_t;

  typedef enum logic [1:0] {
    DEN_1  = 2'd0,
    DEN_2  = 2'd1,
    DEN_5  = 2'd2,
    DEN_10 = 2'd3
  } denom_t;

  // Unit value of each denomination code, indexed by the 2-bit code.
  localparam logic [CASH_W-1:0] DENOM_VAL [4] = '{7'd1, 7'd2, 7'd5, 7'd10};

endpackage

// File: rtl/change_dispenser_denom_select.sv
// Greedy coin picker: the largest denomination that is stocked and does not
// exceed the amount still owed. found=0 when no coin qualifies.
module denom_select
  import change_pkg::*;
(
  input  logic [CASH_W-1:0] remain,
  input  logic [3:0]        empty,
  output logic              found,
  output logic [1:0]        coin_type
);

  // Scan codes in ascending value so the last qualifying (largest) coin wins.
  always_comb begin
    found     = 1'b0;
    coin_type = DEN_1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!empty[i[1:0]] && (DENOM_VAL[i[1:0]] <= remain)) begin
        found     = 1'b1;
        coin_type = i[1:0];
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser controller: pays out an amount coin by coin through a
// hopper handshake, largest stocked denomination first, and reports either
// completion (done) or an abort (fault, with the unpaid remainder).
// Optional build macro CHANGE_DISPENSER_TIMEOUT_EN adds a PAY-state ack
// timeout of TIMEOUT_CYC cycles; without it PAY waits for coin_ack forever.
module change_dispenser
  import change_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CASH_W-1:0] amount,
  input  logic [3:0]        empty,
  input  logic              coin_ack,
  output logic              coin_valid,
  output logic [1:0]        coin_type,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [CASH_W-1:0] short_amt
);

  state_t            state;
  state_t            state_nxt;
  logic [CASH_W-1:0] remain;
  logic [1:0]        coin_type_r;
  logic [CASH_W-1:0] short_amt_r;
  logic              sel_found;
  logic [1:0]        sel_type;
  logic [CASH_W-1:0] pay_val;
  logic [CASH_W-1:0] remain_dec;
  logic              timed_out;

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("change_dispenser: TIMEOUT_CYC must be non-zero");
  end

  denom_select u_denom_select (
    .remain    (remain),
    .empty     (empty),
    .found     (sel_found),
    .coin_type (sel_type)
  );

  // SELECT guarantees the presented coin never exceeds remain.
  assign pay_val    = DENOM_VAL[coin_type_r];
  assign remain_dec = remain - pay_val;

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] pay_cnt;

  // Count PAY cycles without an ack; cleared in SELECT, i.e. on PAY entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pay_cnt <= '0;
    end else if (state == SELECT) begin
      pay_cnt <= '0;
    end else if ((state == PAY) && !coin_ack) begin
      pay_cnt <= pay_cnt + 1'b1;
    end
  end

  // Last allowed PAY cycle: leaving now makes PAY last exactly TIMEOUT_CYC.
  assign timed_out = (pay_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timed_out = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (amount == '0) ? DONE : SELECT;
        end
      end
      SELECT: state_nxt = sel_found ? PAY : FAULT;
      PAY: begin
        if (coin_ack) begin
          state_nxt = (remain_dec == '0) ? DONE : SELECT;
        end else if (timed_out) begin
          state_nxt = FAULT;
        end
      end
      DONE:    state_nxt = IDLE;
      FAULT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Payout datapath: amount owed, presented coin, unpaid remainder on abort.
  always_ff @(posedge clk) begin
    if (!rst) begin
      remain      <= '0;
      coin_type_r <= '0;
      short_amt_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remain      <= amount;
            short_amt_r <= '0;
          end
        end
        SELECT: begin
          if (sel_found) begin
            coin_type_r <= sel_type;
          end
        end
        PAY: begin
          if (coin_ack) begin
            remain <= remain_dec;
          end
        end
        default: ;
      endcase
      // remain is untouched on every path into FAULT, so it is the shortfall.
      if (state_nxt == FAULT) begin
        short_amt_r <= remain;
      end
    end
  end

  // Output decode from state.
  always_comb begin
    coin_valid = (state == PAY);
    done       = (state == DONE);
    fault      = (state == FAULT);
    busy       = (state != IDLE);
  end

  assign coin_type = coin_type_r;
  assign short_amt = short_amt_r;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: PAY-state ack timeout in cycles, used only when CHANGE_DISPENSER_TIMEOUT_EN is defined.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-low.
REQ-004 start  in  1  request to pay out amount; sampled only in IDLE.
REQ-005 amount  in  7  change to dispense, in cash units 0..127, sourced from the refund value.
REQ-006 empty  in  4  hopper empty flags: bit0=1-unit, bit1=2, bit2=5, bit3=10.
REQ-007 coin_ack  in  1  hopper has ejected the presented coin.
REQ-008 coin_valid  out  1  coin request is being presented.
REQ-009 coin_type  out  2  denomination code: 0=1, 1=2, 2=5, 3=10.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse: full amount paid.
REQ-012 fault  out  1  one-cycle pulse: payout aborted.
REQ-013 short_amt  out  7  units left unpaid by the last aborted payout.

Function
REQ-014 The FSM SHALL have states IDLE, SELECT, PAY, DONE and FAULT; coin_valid, done and fault SHALL be decoded from state==PAY, DONE and FAULT respectively.
REQ-015 IDLE with start=1 SHALL latch amount into a 7-bit remain register, clear short_amt, and go to DONE if amount==0, else to SELECT.
REQ-016 SELECT SHALL pick the largest denomination with value<=remain and empty bit clear, register it in coin_type and go to PAY; if none qualifies it SHALL go to FAULT.
REQ-017 In PAY, coin_valid and coin_type SHALL hold stable until coin_ack=1.
REQ-018 On coin_ack=1 in PAY, remain SHALL decrease by the coin value, then go to DONE if the result is 0, else to SELECT.
REQ-019 The first coin_valid SHALL appear 2 cycles after start is sampled; each further coin SHALL appear 2 cycles after the preceding coin_ack.
REQ-020 DONE and FAULT SHALL each last one cycle and return to IDLE; on entering FAULT, short_amt SHALL capture remain.
REQ-021 start outside IDLE and coin_ack outside PAY SHALL be ignored.
REQ-022 An empty change during PAY SHALL NOT withdraw the presented coin; it takes effect at the next SELECT.
REQ-023 The subtraction in remain SHALL never underflow, because SELECT guarantees value<=remain.

Reset
REQ-024 When rst=0 at a clock edge: state=IDLE, remain=0, coin_type=0, short_amt=0; coin_valid, busy, done and fault SHALL be 0 in the following cycle.
REQ-025 A reset in any state, including mid-PAY, SHALL abort the payout with no done or fault pulse.

Configuration
REQ-026 With CHANGE_DISPENSER_TIMEOUT_EN defined, a counter SHALL clear on PAY entry and count PAY cycles without coin_ack; reaching TIMEOUT_CYC SHALL go to FAULT with the coin not deducted.
REQ-027 Without CHANGE_DISPENSER_TIMEOUT_EN, PAY SHALL wait indefinitely, no counter logic SHALL exist, and FAULT SHALL be reachable only from SELECT.

Structure
REQ-028 Package change_pkg SHALL hold: CASH_W=7, the state enum, the 2-bit denomination codes, the DENOM_VAL table (1,2,5,10) and the TIMEOUT_CYC default.
REQ-029 Combinational sub-module denom_select (inputs remain and empty; outputs found and coin_type) SHALL implement the greedy pick.

Verification
REQ-030 amount=27, all hoppers stocked, ack 1 cycle after each coin_valid -> coin sequence 10,10,5,2; done pulse; fault never asserted.
REQ-031 amount=0 -> no coin_valid; done high in the cycle after start is sampled.
REQ-032 amount=9, empty=0100 (5-unit hopper empty) -> coin sequence 2,2,2,2,1; then done.
REQ-033 amount=7, empty=0011 -> one 5-unit coin, then fault with short_amt=2.
REQ-034 start pulsed while busy, and coin_ack pulsed in SELECT -> no effect on remain or the coin sequence; rst=0 during PAY -> coin_valid=0 in the next cycle, with no done or fault pulse.
REQ-035 With the macro defined and TIMEOUT_CYC=16, amount=10 and coin_ack held low -> fault after 16 PAY cycles, short_amt=10.
